// File: rtl/display_timing_if.sv
// Bundle between the display timing generator and its consumer: the pixel
// strobe goes in; counts, syncs and frame-address controls come out.
interface display_timing_if;
   logic       Enable;
   logic [9:0] HCount;
   logic [9:0] VCount;
   logic       HSync;
   logic       VSync;
   logic       VideoOn;
   logic       IncAddr1;
   logic       ResetAddr1;
   logic       FrameStart;

   modport master (
      input  Enable,
      output HCount, VCount, HSync, VSync, VideoOn, IncAddr1, ResetAddr1, FrameStart
   );

   modport slave (
      output Enable,
      input  HCount, VCount, HSync, VSync, VideoOn, IncAddr1, ResetAddr1, FrameStart
   );
endinterface

// File: rtl/display_timing.sv
// Raster timing generator: pixel/line counters with registered sync, blanking
// and frame-address decodes that stay cycle-aligned with the counts.
module display_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic             clk,
   input  logic             Reset,
   display_timing_if.master bus
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       von_q, von_d;
   logic       rstaddr_q, rstaddr_d;
   logic       fstart_q, fstart_d;

   // Reset parks the position on the last pixel so the first enabled edge lands on (0,0).
   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (Reset) begin
         hcnt_d = H_LAST;
         vcnt_d = V_LAST;
      end else if (bus.Enable) begin
         if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
         end else begin
            hcnt_d = hcnt_q + 10'd1;
         end
      end
   end

   // Decoding the next position lets the registered flags line up with the counts.
   always_comb begin
      hsync_d   = !((hcnt_d >= HS_FIRST) && (hcnt_d <= HS_LAST));
      vsync_d   = !((vcnt_d >= VS_FIRST) && (vcnt_d <= VS_LAST));
      von_d     = (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
      rstaddr_d = (hcnt_d == H_LAST) && (vcnt_d == V_LAST);
      fstart_d  = (hcnt_d == '0) && (vcnt_d == '0);
      if (Reset) begin
         hsync_d   = 1'b1;
         vsync_d   = 1'b1;
         von_d     = 1'b0;
         rstaddr_d = 1'b1;
         fstart_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      von_q     <= von_d;
      rstaddr_q <= rstaddr_d;
      fstart_q  <= fstart_d;
   end

   assign bus.HCount     = hcnt_q;
   assign bus.VCount     = vcnt_q;
   assign bus.HSync      = hsync_q;
   assign bus.VSync      = vsync_q;
   assign bus.VideoOn    = von_q;
   assign bus.ResetAddr1 = rstaddr_q;
   assign bus.FrameStart = fstart_q;
   // Gated by the live strobe so stalled cycles never advance the frame address.
   assign bus.IncAddr1   = von_q & bus.Enable;

endmodule

// File: tb/tb_display_timing.sv
// Scoreboard bench for display_timing on a scaled-down raster; a reference
// position model queues expected outputs per driven cycle.
module tb_display_timing;

   localparam int HA = 8, HF = 2, HS = 3, HB = 2;
   localparam int VA = 5, VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       von;
      logic       inc;
      logic       ra;
      logic       fs;
   } exp_t;

   logic clk = 1'b0;
   logic Reset = 1'b1;
   display_timing_if tif ();

   display_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk  (clk),
      .Reset(Reset),
      .bus  (tif)
   );

   always #5 clk = ~clk;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail = 0;
   int   m_h = 0;
   int   m_v = 0;
   int   inc_cnt = 0;
   int   frames_checked = 0;
   bit   seen_fs = 0;
   logic ra_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus and queue what the DUT must show after that edge.
   task automatic step(input logic rst, input logic en);
      exp_t e;
      @(negedge clk);
      Reset = rst;
      tif.Enable = en;
      if (rst) begin
         m_h = HT - 1;
         m_v = VT - 1;
      end else if (en) begin
         if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
         end else begin
            m_h = m_h + 1;
         end
      end
      e.h   = 10'(m_h);
      e.v   = 10'(m_v);
      e.hs  = !(m_h >= HA + HF && m_h < HA + HF + HS);
      e.vs  = !(m_v >= VA + VF && m_v < VA + VF + VS);
      e.von = (m_h < HA) && (m_v < VA);
      e.inc = e.von && en;
      e.ra  = (m_h == HT - 1) && (m_v == VT - 1);
      e.fs  = (m_h == 0) && (m_v == 0);
      sb_q.push_back(e);
   endtask

   always @(posedge clk) begin
      #1;
      if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         check("hcount",   tif.HCount,     mon_e.h);
         check("vcount",   tif.VCount,     mon_e.v);
         check("hsync",    tif.HSync,      mon_e.hs);
         check("vsync",    tif.VSync,      mon_e.vs);
         check("videoon",  tif.VideoOn,    mon_e.von);
         check("incaddr",  tif.IncAddr1,   mon_e.inc);
         check("rstaddr",  tif.ResetAddr1, mon_e.ra);
         check("fstart",   tif.FrameStart, mon_e.fs);
         check("inc_and_rstaddr", tif.IncAddr1 & tif.ResetAddr1, 0);
         if (Reset) seen_fs = 0;
         if (tif.ResetAddr1 && !ra_prev) begin
            if (seen_fs) begin
               check("pix_per_frame", inc_cnt, HA * VA);
               frames_checked++;
            end
            inc_cnt = 0;
            seen_fs = 0;
         end
         ra_prev = tif.ResetAddr1;
         if (tif.FrameStart) seen_fs = 1;
         if (tif.IncAddr1) inc_cnt++;
      end
   end

   initial begin
      tif.Enable = 1'b1;
      // Reset held with Enable high, then two full frames at full rate.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 2 * FT; i++) step(1'b0, 1'b1);
      // One frame with Enable on every fourth cycle.
      for (int i = 0; i < 4 * FT; i++) step(1'b0, (i % 4) == 3);
      // Mid-frame reset, then a full frame afterwards.
      for (int i = 0; i < 2 * FT && !(m_h == HA / 2 && m_v == VA / 2); i++) step(1'b0, 1'b1);
      check("reach_mid", (m_h == HA / 2 && m_v == VA / 2), 1);
      step(1'b1, 1'b1);
      for (int i = 0; i < FT; i++) step(1'b0, 1'b1);
      // Hold at the wrap corner, then release.
      check("at_corner", (m_h == HT - 1 && m_v == VT - 1), 1);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
      @(posedge clk);
      #3;
      check("sb_drain", sb_q.size(), 0);
      check("frames_seen", frames_checked, 4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
